vga_timing_gen: RTL
===================

# vga_timing_gen

Raster timing generator for the 640x480@60 Hz VGA path, clocked by the 25 MHz `vga_clk`. It runs the horizontal and vertical counters and drives sync, data-enable and RGB to the DAC/connector. It also issues the pixel coordinate request to the pixel-data source one cycle ahead of display. The source returns a registered `pixel_data` one cycle after it sees `pixel_xpos`/`pixel_ypos`.

## Interface
Parameters:
- `H_SYNC`, 96: hsync pulse width, in clocks.
- `H_BACK`, 48: horizontal back porch.
- `H_DISP`, 640: active pixels per line.
- `H_FRONT`, 16: horizontal front porch.
- `H_TOTAL`, 800: clocks per line; must equal the sum of the four above.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.
- `V_DISP`, 480: active lines.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_TOTAL`, 525: lines per frame.

Ports:
- `vga_clk` in 1: pixel clock, 25 MHz; all logic on its rising edge.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `pixel_data` in 16: RGB565 from the pixel source, valid 1 cycle after the request.
- `pixel_xpos` out 10: requested column, 0..H_DISP-1; 0 when no request.
- `pixel_ypos` out 10: requested row, 0..V_DISP-1; 0 when no request.
- `vga_hs` out 1: horizontal sync, active-low.
- `vga_vs` out 1: vertical sync, active-low.
- `vga_de` out 1: active-video enable.
- `vga_rgb` out 16: pixel to the DAC; 0 outside active video.
- `frame_start` out 1: one-cycle pulse marking the first clock of a frame.
- `frame_cnt` out 8: frames completed, wrapping.

## Operation
- `cnt_h` (10 bit) counts 0..H_TOTAL-1 every clock.
  - It wraps to 0 after H_TOTAL-1.
- `cnt_v` (10 bit) increments only in the cycle where `cnt_h == H_TOTAL-1`.
  - It wraps to 0 after V_TOTAL-1.
- `vga_hs = (cnt_h >= H_SYNC)`, so it is low for `cnt_h` 0..95.
- `vga_vs = (cnt_v >= V_SYNC)`, so it is low for lines 0..1.
- Active window:
  - `h_act`: `cnt_h` in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP-1] = [144, 783].
  - `v_act`: `cnt_v` in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP-1] = [35, 514].
  - `vga_de = h_act & v_act`.
- Request window:
  - `data_req`: `cnt_h` in [143, 782] with `v_act`; this is the active window shifted one clock earlier.
  - `pixel_xpos = cnt_h - 143` while `data_req`, else 0.
  - `pixel_ypos = cnt_v - 35` while `data_req`, else 0.
  - All subtraction is 10-bit unsigned and only evaluated inside the window, so there is no underflow.
- `vga_rgb = vga_de ? pixel_data : 16'h0000`.
- `frame_start` and `frame_cnt` are registered:
  - The update event is `cnt_h == H_TOTAL-1 && cnt_v == V_TOTAL-1`.
  - On that event, `frame_start` goes high for the next clock, which coincides with the counters reading (0,0).
  - On the same event, `frame_cnt` increments; 255 wraps to 0.
- Sync, enable, coordinates and `vga_rgb` are combinational decodes of the counter registers. They must be glitch-tolerant for the DAC only; no extra register stage.

## Timing
- Reset values (while `sys_rst_n` is low and immediately after release):
  - `cnt_h = 0`, `cnt_v = 0`.
  - `vga_hs = 0`, `vga_vs = 0`, `vga_de = 0`, `vga_rgb = 0`.
  - `pixel_xpos = 0`, `pixel_ypos = 0`.
  - `frame_start = 0`, `frame_cnt = 0`.
- After release, counting starts at (0,0) on the first rising edge.
  - The first frame after reset gets no `frame_start` pulse.
  - The first pulse comes when the counters reach (0,0) again, 420000 clocks after reset release.
- Request-to-display latency is exactly 1 clock.
  - Request (x, y) is issued at `cnt_h = 143 + x`.
  - The matching `pixel_data` is shown on `vga_rgb` at `cnt_h = 144 + x`.
- Per line: `data_req` high 640 clocks, `vga_de` high 640 clocks, `vga_hs` low 96 clocks.
- Per frame: `vga_de` high on 480 lines, `vga_vs` low for 1600 clocks, period 420000 clocks.
- Line wrap: at `cnt_h = 799` `cnt_v` advances.
  - At `cnt_v = 524` both counters return to 0 on the same edge.
  - That edge also clears `vga_vs` low.
- Reset asserted mid-frame: all state returns to reset values asynchronously, without waiting for a clock edge.
- No handshake back-pressure: the pixel source must always answer within 1 clock.

## Test plan
- Hold reset 10 clocks, then release -> all outputs hold their reset values during reset; `vga_hs` rises exactly at clock 96 after release; `frame_start` stays 0 for the first 420000 clocks.
- Run one full line on an active row (row 35) -> `vga_hs` low 96 clocks; `pixel_xpos` = 0 at `cnt_h` 143 and 639 at `cnt_h` 782; `vga_de` high exactly on `cnt_h` 144..783.
- Model the pixel source as a register returning {x[4:0], y[5:0], x[4:0]} -> every `vga_rgb` sample inside `vga_de` matches the coordinates requested one clock earlier; `vga_rgb` = 0 outside `vga_de`.
- Run 3 full frames -> `frame_start` pulses are exactly 420000 clocks apart; `vga_vs` is low 1600 clocks per frame; 480 `vga_de` lines per frame; `frame_cnt` reads 0, 1, 2, 3 across the pulses.
- Preload `frame_cnt` to 255 via forced counting over 256 frames, or force it in the bench -> the next pulse wraps it to 0.
- Assert reset at `cnt_h = 400`, `cnt_v = 200` for 3 clocks -> outputs go to reset values immediately; after release the line timing restarts from (0,0), with `vga_hs` low for 96 clocks.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, sync/DE decode and a pixel request issued one clock ahead of display.
module vga_timing_gen #(
   parameter int H_SYNC  = 96,
   parameter int H_BACK  = 48,
   parameter int H_DISP  = 640,
   parameter int H_FRONT = 16,
   parameter int H_TOTAL = 800,
   parameter int V_SYNC  = 2,
   parameter int V_BACK  = 33,
   parameter int V_DISP  = 480,
   parameter int V_FRONT = 10,
   parameter int V_TOTAL = 525
) (
   input  logic        vga_clk,
   input  logic        sys_rst_n,
   input  logic [15:0] pixel_data,
   output logic [9:0]  pixel_xpos,
   output logic [9:0]  pixel_ypos,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_de,
   output logic [15:0] vga_rgb,
   output logic        frame_start,
   output logic [7:0]  frame_cnt
);
   localparam logic [9:0] H_ACT_LO = 10'(H_SYNC + H_BACK);
   localparam logic [9:0] H_ACT_HI = 10'(H_SYNC + H_BACK + H_DISP - 1);
   localparam logic [9:0] V_ACT_LO = 10'(V_SYNC + V_BACK);
   localparam logic [9:0] V_ACT_HI = 10'(V_SYNC + V_BACK + V_DISP - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);

   if (H_TOTAL != H_SYNC + H_BACK + H_DISP + H_FRONT) begin : g_bad_h_total
      $error("H_TOTAL must equal the sum of the horizontal intervals");
   end
   if (V_TOTAL != V_SYNC + V_BACK + V_DISP + V_FRONT) begin : g_bad_v_total
      $error("V_TOTAL must equal the sum of the vertical intervals");
   end

   logic [9:0] r_cnt_h;
   logic [9:0] r_cnt_v;
   logic       r_frame_start;
   logic [7:0] r_frame_cnt;
   logic       w_h_end;
   logic       w_v_end;
   logic       w_h_act;
   logic       w_v_act;
   logic       w_req;

   assign w_h_end = r_cnt_h == H_LAST;
   assign w_v_end = r_cnt_v == V_LAST;

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_cnt_h       <= '0;
         r_cnt_v       <= '0;
         r_frame_start <= 1'b0;
         r_frame_cnt   <= '0;
      end else begin
         r_cnt_h       <= w_h_end ? '0 : r_cnt_h + 10'd1;
         if (w_h_end) r_cnt_v <= w_v_end ? '0 : r_cnt_v + 10'd1;
         r_frame_start <= w_h_end & w_v_end;
         if (w_h_end & w_v_end) r_frame_cnt <= r_frame_cnt + 8'd1;
      end
   end

   // Request window is the active window moved one clock earlier to cover the source's register stage.
   always_comb begin
      w_h_act    = r_cnt_h >= H_ACT_LO && r_cnt_h <= H_ACT_HI;
      w_v_act    = r_cnt_v >= V_ACT_LO && r_cnt_v <= V_ACT_HI;
      w_req      = r_cnt_h >= H_ACT_LO - 10'd1 && r_cnt_h <= H_ACT_HI - 10'd1 && w_v_act;
      vga_hs     = r_cnt_h >= 10'(H_SYNC);
      vga_vs     = r_cnt_v >= 10'(V_SYNC);
      vga_de     = w_h_act & w_v_act;
      vga_rgb    = vga_de ? pixel_data : 16'h0000;
      pixel_xpos = w_req ? r_cnt_h - (H_ACT_LO - 10'd1) : '0;
      pixel_ypos = w_req ? r_cnt_v - V_ACT_LO : '0;
   end

   assign frame_start = r_frame_start;
   assign frame_cnt   = r_frame_cnt;
endmodule
